shift_rows_pipe: RTL and testbench
==================================

Name: shift_rows_pipe

Overview:
Parametrised, registered ShiftRows/InvShiftRows stage for the AES/Rijndael datapath. Supports block widths Nb = 4, 6 or 8 columns. Direction is selectable per transfer. Valid/ready handshakes on both sides, with a 2-entry skid buffer, so the stage can sit between the round-key adder and the S-box stage without breaking timing on the ready path.

Parameters:
NB, 4, number of state columns; legal values 4, 6, 8; any other value is a compile-time error.
W, 32*NB, state width in bits; derived, must not be overridden.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input state valid
in_ready  out  1  stage can accept input this cycle
in_inv  in  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt); sampled with in_data
in_data  in  W  input state
out_valid  out  1  output state valid
out_ready  in  1  downstream accepts output
out_data  out  W  shifted state
busy  out  1  at least one entry held

Behaviour:
- Byte layout: byte k = r + 4c (row r 0..3, column c 0..NB-1) occupies in_data[W-1-8k -: 8]. This is column-major with byte 0 in the MSBs, matching FIPS-197 hex order.
- Row offsets s_r:
  - NB=4 or 6: 0, 1, 2, 3
  - NB=8: 0, 1, 3, 4
- Forward: out[r][c] = in[r][(c + s_r) mod NB].
- Inverse: out[r][(c + s_r) mod NB] = in[r][c].
- The permutation is combinational on the accepted input and is captured into the buffer on acceptance. No arithmetic is involved; only byte routing.
- Buffer: 2 entries (main, skid) and a 2-bit count 0..2.
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- in_ready = (count < 2). It is registered, i.e. derived from the registered count only; no combinational path from out_ready.
- out_valid = (count != 0).
- out_data always shows the oldest entry.
- Latency: input accepted at edge N appears on out_data with out_valid=1 after edge N; first possible output transfer is in cycle N+1. Throughput is 1 state/cycle when out_ready is held high.
- Simultaneous events:
  - Input and output transfer in the same cycle: count unchanged, FIFO order preserved.
  - count=2: in_ready=0, and in_valid is ignored.
  - count=0: out_data holds its last value, and out_valid=0.
- Ordering is strict FIFO; in_inv travels with its own data, so a mode change between transfers needs no flush.
- Handshake rule: a held output (out_valid=1, out_ready=0) keeps out_data stable until transferred.
- Reset (any time, including mid-transfer): count=0, out_valid=0, busy=0, in_ready=0 while rst is high and 1 in the first cycle after release. out_data resets to all zeros. In-flight data is discarded.
- busy = (count != 0).

Optional Feature:
SHIFT_ROWS_BYPASS_EN:
- Defined: adds input port in_bypass (1 bit), sampled with in_data. When 1, the state is stored unpermuted, regardless of in_inv. This is used for the final-round and debug paths.
- Undefined: no in_bypass port; every transfer is permuted per in_inv.

Test Plan:
- NB=4, forward, in_data=d42711aee0bf98f1b8b45de51e415230 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_valid high one cycle after acceptance.
- NB=4, inverse, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=d42711aee0bf98f1b8b45de51e415230.
- NB=8, forward then inverse on bytes 00..1f (byte k = k) -> round-trip returns 000102...1f. Forward row 2 reads columns shifted by 3; row 3 reads columns shifted by 4.
- Backpressure: out_ready=0, issue 3 valid inputs A,B,C -> A,B accepted, in_ready=0 during C. Raise out_ready -> A,B,C emerge in order, with no loss or duplication.
- Alternate in_inv every cycle with out_ready=1 -> one output per cycle, each permuted per its own in_inv.
- Assert rst with count=2 -> out_valid=0 and busy=0 immediately. After release, the next input appears after one cycle and the old data is never emitted.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// AES ShiftRows/InvShiftRows stage for Nb = 4/6/8, with a 2-entry valid/ready buffer.
// Optional macro SHIFT_ROWS_BYPASS_EN adds in_bypass (store the state unpermuted).
module shift_rows_pipe #(
  parameter  int unsigned NB = 4,
  localparam int unsigned W  = 32 * NB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
`ifdef SHIFT_ROWS_BYPASS_EN
  input  logic         in_bypass,
`endif
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0] w_fwd;
  logic [W-1:0] w_inv;
  logic [W-1:0] w_perm;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_count_nxt;

  logic [1:0]   r_count;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;

  // Pure byte routing; byte k = r + 4c sits at bits [W-1-8k -: 8].
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned SR  = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int unsigned FWD = (c + SR) % NB;
      localparam int unsigned INV = (c + NB - SR) % NB;
      localparam int unsigned DST = r + 4 * c;
      assign w_fwd[W-1-8*DST -: 8] = in_data[W-1-8*(r+4*FWD) -: 8];
      assign w_inv[W-1-8*DST -: 8] = in_data[W-1-8*(r+4*INV) -: 8];
    end
  end

  always_comb begin
    w_perm = in_inv ? w_inv : w_fwd;
`ifdef SHIFT_ROWS_BYPASS_EN
    if (in_bypass) w_perm = in_data;
`endif
  end

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 2'd1;
  end

  // r_main is always the oldest entry; ready/valid flags follow the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
      case (r_count)
        2'd0: if (w_push) r_main <= w_perm;
        2'd1: begin
          if (w_push && w_pop) r_main <= w_perm;
          else if (w_push)     r_skid <= w_perm;
        end
        2'd2: if (w_pop) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign busy      = r_out_valid;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4 and NB=8 instances, handshake, reset.
module tb_shift_rows_pipe;

  localparam logic [127:0] X4  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] Y4  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] K4  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K4F = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] K4I = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [255:0] K8  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K8F =
    256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, busy8;
  logic [255:0] in_data8, out_data8;

  int n_tests = 0;
  int n_fail  = 0;

  shift_rows_pipe #(.NB(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
`ifdef SHIFT_ROWS_BYPASS_EN
    .in_bypass(1'b0),
`endif
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  shift_rows_pipe #(.NB(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8),
`ifdef SHIFT_ROWS_BYPASS_EN
    .in_bypass(1'b0),
`endif
    .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_inv8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b data=%h, want 0 0 0 0",
               out_valid, busy, in_ready, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b/%b, want 1/1", in_ready, in_ready8);
    end
  endtask

  task automatic test_forward();
    in_valid = 1'b1; in_inv = 1'b0; in_data = X4; out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fwd_pre_valid: got %b, want 0", out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== Y4 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_nb4: valid=%b busy=%b data=%h, want 1 1 %h", out_valid, busy, out_data, Y4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== Y4) begin
      n_fail++;
      $display("FAIL fwd_drain_hold: valid=%b busy=%b data=%h, want 0 0 %h", out_valid, busy, out_data, Y4);
    end
  endtask

  task automatic test_inverse();
    logic [127:0] din [3];
    logic         inv [3];
    logic [127:0] exp [3];
    din[0] = Y4; inv[0] = 1'b1; exp[0] = X4;
    din[1] = K4; inv[1] = 1'b0; exp[1] = K4F;
    din[2] = K4; inv[2] = 1'b1; exp[2] = K4I;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inv = inv[i]; in_data = din[i];
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        n_fail++;
        $display("FAIL nb4_vec%0d: valid=%b data=%h, want 1 %h", i, out_valid, out_data, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_nb8();
    out_ready8 = 1'b1;
    in_valid8 = 1'b1; in_inv8 = 1'b0; in_data8 = K8;
    @(negedge clk);
    n_tests++;
    if (out_valid8 !== 1'b1 || out_data8 !== K8F) begin
      n_fail++;
      $display("FAIL nb8_fwd: valid=%b data=%h, want 1 %h", out_valid8, out_data8, K8F);
    end
    in_inv8 = 1'b1; in_data8 = out_data8;
    @(negedge clk);
    in_valid8 = 1'b0;
    n_tests++;
    if (out_valid8 !== 1'b1 || out_data8 !== K8) begin
      n_fail++;
      $display("FAIL nb8_roundtrip: valid=%b data=%h, want 1 %h", out_valid8, out_data8, K8);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL nb8_drain: valid=%b busy=%b, want 0 0", out_valid8, busy8);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inv = 1'b0; in_data = X4;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_after_a: got %b, want 1", in_ready);
    end
    in_inv = 1'b0; in_data = K4;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_full: ready=%b busy=%b, want 0 1", in_ready, busy);
    end
    in_inv = 1'b1; in_data = Y4;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== Y4) begin
      n_fail++;
      $display("FAIL bp_hold_a: ready=%b valid=%b data=%h, want 0 1 %h", in_ready, out_valid, out_data, Y4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== K4F || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_out_b: valid=%b ready=%b data=%h, want 1 1 %h", out_valid, in_ready, out_data, K4F);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== X4) begin
      n_fail++; $display("FAIL bp_out_c: valid=%b data=%h, want 1 %h", out_valid, out_data, X4);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty: valid=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_inv   = (i % 2 == 1);
      in_data  = (i % 2 == 1) ? Y4 : X4;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== ((i % 2 == 1) ? X4 : Y4)) begin
        n_fail++;
        $display("FAIL alt_inv%0d: valid=%b ready=%b data=%h, want 1 1 %h", i, out_valid, in_ready,
                 out_data, (i % 2 == 1) ? X4 : Y4);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL alt_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inv = 1'b0; in_data = X4;
    @(negedge clk);
    in_data = K4;
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rm_full: busy=%b ready=%b, want 1 0", busy, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL rm_async: valid=%b busy=%b ready=%b data=%h, want 0 0 0 0",
               out_valid, busy, in_ready, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_release: ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
    in_valid = 1'b1; in_inv = 1'b1; in_data = K4;
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== K4I) begin
      n_fail++; $display("FAIL rm_new: valid=%b data=%h, want 1 %h", out_valid, out_data, K4I);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== K4I) begin
      n_fail++;
      $display("FAIL rm_no_old: valid=%b busy=%b data=%h, want 0 0 %h", out_valid, busy, out_data, K4I);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_nb8();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
